// File: rtl/gpr_bank.sv
// gpr_bank: parametrised register file with two write ports, sticky overflow flag,
// optional write-to-read bypass and optional registered read ports.
module gpr_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned READ_REG = 0,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned GP_IDX   = 28,
  parameter logic [31:0] GP_INIT  = 32'h0000_1800,
  parameter int unsigned SP_IDX   = 29,
  parameter logic [31:0] SP_INIT  = 32'h0000_2ffc,
  parameter int unsigned FLAG_IDX = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  ovf_set,
  input  logic                  ovf_clr,
  output logic                  ovf_flag
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] GP_RST = DATA_W'(GP_INIT);
  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] nxt  [DEPTH];

  function automatic logic [DATA_W-1:0] rst_val(input int unsigned idx);
    if (idx == GP_IDX) return GP_RST;
    if (idx == SP_IDX) return SP_RST;
    return '0;
  endfunction

  // Post-edge contents: port 0, then port 1 (wins collisions), then clear, then set.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt[i] = regs[i];
      if (i != 0) begin
        if (we0 && (waddr0 == ADDR_W'(i))) nxt[i] = wdata0;
        if (we1 && (waddr1 == ADDR_W'(i))) nxt[i] = wdata1;
      end
      if (i == FLAG_IDX) begin
        if (ovf_clr) nxt[i][0] = 1'b0;
        if (ovf_set) nxt[i][0] = 1'b1;
      end
    end
  end

  // Register array state; r0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= rst_val(i);
    end else begin
      regs <= nxt;
    end
  end

  assign ovf_flag = regs[FLAG_IDX][0];

  if (READ_REG != 0) begin : g_rreg
    logic [NRD*DATA_W-1:0] rd_q;

    // Registered reads return the post-edge (write-first) contents.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q <= '0;
      end else begin
        for (int unsigned k = 0; k < NRD; k++) begin
          rd_q[k*DATA_W +: DATA_W] <= nxt[raddr[k*ADDR_W +: ADDR_W]];
        end
      end
    end

    assign rdata = rd_q;
  end else begin : g_creg
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    // Combinational reads with optional forwarding of same-cycle write data (port 1 first).
    always_comb begin
      rdata = '0;
      ra    = '0;
      rv    = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
        ra = raddr[k*ADDR_W +: ADDR_W];
        rv = regs[ra];
        if ((BYPASS != 0) && (ra != '0)) begin
          if (we1 && (waddr1 == ra))      rv = wdata1;
          else if (we0 && (waddr0 == ra)) rv = wdata0;
        end
        rdata[k*DATA_W +: DATA_W] = rv;
      end
    end
  end

endmodule

// File: tb/tb_gpr_bank.sv
// Directed bench for gpr_bank: combinational/bypass instance plus a registered-read instance.
module tb_gpr_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (32-bit, 2 ports, combinational reads, bypass on)
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic        a_we0, a_we1, a_set, a_clr, a_flag;
  logic [4:0]  a_wa0, a_wa1;
  logic [31:0] a_wd0, a_wd1;

  gpr_bank u_a (
    .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata),
    .we0(a_we0), .waddr0(a_wa0), .wdata0(a_wd0),
    .we1(a_we1), .waddr1(a_wa1), .wdata1(a_wd1),
    .ovf_set(a_set), .ovf_clr(a_clr), .ovf_flag(a_flag)
  );

  // Instance B: 16-bit, 64 entries, 3 registered read ports
  logic [17:0] b_raddr;
  logic [47:0] b_rdata;
  logic        b_we0, b_we1, b_set, b_clr, b_flag;
  logic [5:0]  b_wa0, b_wa1;
  logic [15:0] b_wd0, b_wd1;

  gpr_bank #(.DATA_W(16), .ADDR_W(6), .NRD(3), .READ_REG(1)) u_b (
    .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata),
    .we0(b_we0), .waddr0(b_wa0), .wdata0(b_wd0),
    .we1(b_we1), .waddr1(b_wa1), .wdata1(b_wd1),
    .ovf_set(b_set), .ovf_clr(b_clr), .ovf_flag(b_flag)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        set;
    logic        clr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;  // same-cycle read, port 0
    logic [31:0] e_rd1;  // same-cycle read, port 1
    logic        e_flag; // flag before this vector's edge
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  task automatic a_idle();
    a_we0 = 1'b0; a_wa0 = '0; a_wd0 = '0;
    a_we1 = 1'b0; a_wa1 = '0; a_wd1 = '0;
    a_set = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_idle();
    b_we0 = 1'b0; b_wa0 = '0; b_wd0 = '0;
    b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
    b_set = 1'b0; b_clr = 1'b0;
  endtask

  initial begin
    //          we0 wa0 wd0            we1 wa1 wd1           set  clr  ra0 ra1 e_rd0          e_rd1          flag
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd28,5'd29, 32'h0000_1800, 32'h0000_2ffc, 1'b0};
    tbl[1]  = '{1'b1, 5'd7,  32'hDEAD_BEEF,1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd5, 5'd7,  32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd0, 5'd7,  32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 5'd9,  32'h1111,     1'b1, 5'd9,  32'h2222, 1'b0,1'b0, 5'd9, 5'd0,  32'h2222,      32'h0,         1'b0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd9, 5'd0,  32'h2222,      32'h0,         1'b0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 32'hF0,   1'b0,1'b0, 5'd30,5'd9,  32'hF0,        32'h2222,      1'b0};
    tbl[6]  = '{1'b1, 5'd30, 32'h0,        1'b0, 5'd0,  32'h0,    1'b1,1'b1, 5'd30,5'd7,  32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b1, 5'd30,5'd0,  32'h1,         32'h0,         1'b1};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd30,5'd0,  32'h0,         32'h0,         1'b0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1,1'b0, 5'd30,5'd0,  32'h0,         32'h0,         1'b0};
    tbl[10] = '{1'b1, 5'd30, 32'hFFFF_FFFE,1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd30,5'd0,  32'hFFFF_FFFE, 32'h0,         1'b1};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd30,5'd0,  32'hFFFF_FFFE, 32'h0,         1'b0};
    tbl[12] = '{1'b1, 5'd4,  32'hAAAA,     1'b1, 5'd5,  32'hBBBB, 1'b0,1'b0, 5'd4, 5'd5,  32'hAAAA,      32'hBBBB,      1'b0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd5, 5'd4,  32'hBBBB,      32'hAAAA,      1'b0};
    tbl[14] = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,    1'b0,1'b0, 5'd6, 5'd29, 32'h66,        32'h0000_2ffc, 1'b0};

    a_idle();
    b_idle();
    a_raddr = {5'd29, 5'd28};
    b_raddr = {6'd40, 6'd29, 6'd28};

    // Asynchronous reset between edges, checked with no clock edge
    #3 rst = 1'b0;
    #1;
    chk("rst r28", a_rdata[31:0],  32'h0000_1800);
    chk("rst r29", a_rdata[63:32], 32'h0000_2ffc);
    chk("rst a flag", {31'h0, a_flag}, 32'h0);
    chk("rst b rdata lo", b_rdata[31:0], 32'h0);
    chk("rst b rdata hi", {16'h0, b_rdata[47:32]}, 32'h0);
    chk("rst b flag", {31'h0, b_flag}, 32'h0);
    a_raddr = {5'd0, 5'd5};
    #1;
    chk("rst r5", a_rdata[31:0], 32'h0);

    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors on instance A
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      a_we0 = tbl[i].we0; a_wa0 = tbl[i].wa0; a_wd0 = tbl[i].wd0;
      a_we1 = tbl[i].we1; a_wa1 = tbl[i].wa1; a_wd1 = tbl[i].wd1;
      a_set = tbl[i].set; a_clr = tbl[i].clr;
      a_raddr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("v%0d rd0", i), a_rdata[31:0], tbl[i].e_rd0);
      chk($sformatf("v%0d rd1", i), a_rdata[63:32], tbl[i].e_rd1);
      chk($sformatf("v%0d flag", i), {31'h0, a_flag}, {31'h0, tbl[i].e_flag});
    end
    @(negedge clk);
    a_idle();

    // Registered reads: write r40 with raddr2 = 40 in the same cycle
    b_raddr = {6'd40, 6'd29, 6'd28};
    b_we0 = 1'b1; b_wa0 = 6'd40; b_wd0 = 16'hABCD;
    #1;
    chk("b rd2 pre-edge", {16'h0, b_rdata[47:32]}, 32'h0);
    @(posedge clk);
    #1;
    chk("b rd2 ABCD", {16'h0, b_rdata[47:32]}, 32'h0000_ABCD);
    chk("b rd0 gp trunc", {16'h0, b_rdata[15:0]}, 32'h0000_1800);
    chk("b rd1 sp trunc", {16'h0, b_rdata[31:16]}, 32'h0000_2ffc);
    @(negedge clk);
    b_idle();
    b_raddr = {6'd0, 6'd0, 6'd30};
    b_set = 1'b1;
    #1;
    chk("b rd2 held", {16'h0, b_rdata[47:32]}, 32'h0000_ABCD);
    @(posedge clk);
    #1;
    chk("b rd2 r0", {16'h0, b_rdata[47:32]}, 32'h0);
    chk("b rd0 flag wf", {16'h0, b_rdata[15:0]}, 32'h1);
    chk("b flag set", {31'h0, b_flag}, 32'h1);
    @(negedge clk);
    b_idle();

    // Reset asserted mid-cycle while port 1 targets r3
    a_raddr = {5'd7, 5'd3};
    a_we1 = 1'b1; a_wa1 = 5'd3; a_wd1 = 32'h5555;
    #2 rst = 1'b0;
    #1;
    chk("mid rst b flag", {31'h0, b_flag}, 32'h0);
    chk("mid rst b rdata", b_rdata[31:0], 32'h0);
    @(posedge clk);
    #1;
    a_idle();
    #1;
    chk("mid rst r3", a_rdata[31:0], 32'h0);
    chk("mid rst r7", a_rdata[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post rst r3", a_rdata[31:0], 32'h0);
    a_we1 = 1'b1; a_wa1 = 5'd3; a_wd1 = 32'h7777;
    @(posedge clk);
    #1;
    a_idle();
    #1;
    chk("first write r3", a_rdata[31:0], 32'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register file for the MIPS single/multi-cycle datapaths. It supersedes the fixed 32×32, two-read, one-write file with configurable width, depth and read-port count, two write ports with defined collision priority, optional same-cycle write-to-read bypass, optional registered (synchronous) reads, and a sticky overflow flag with an explicit clear. It sits between decode (read addresses) and write-back (ALU/memory results, overflow indication).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W (minimum ADDR_W = 5)
- NRD, 2, number of read ports
- READ_REG, 0, 0 = combinational reads; 1 = registered reads, 1-cycle latency
- BYPASS, 1, 1 = same-cycle write data forwarded to combinational reads (READ_REG = 0 only)
- GP_IDX, 28, global-pointer index; GP_INIT, 32'h0000_1800, its reset value
- SP_IDX, 29, stack-pointer index; SP_INIT, 32'h0000_2ffc, its reset value
- FLAG_IDX, 30, register holding the sticky overflow flag in bit 0
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- raddr  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- we0, waddr0, wdata0  in  1, ADDR_W, DATA_W  write port 0
- we1, waddr1, wdata1  in  1, ADDR_W, DATA_W  write port 1
- ovf_set  in  1  overflow pulse from addi/add unit
- ovf_clr  in  1  clear the sticky overflow flag
- ovf_flag  out  1  current value of register[FLAG_IDX][0]

## Operation
- Reset (rst = 0, asynchronous): register[GP_IDX] = GP_INIT, register[SP_IDX] = SP_INIT, all others 0. Init constants are truncated or zero-extended to DATA_W. Registered rdata = 0. ovf_flag = 0.
- Register 0: writes ignored on both ports; reads always return 0, including through bypass.
- Writes: on the rising edge, if weN = 1 and waddrN ≠ 0, register[waddrN] ← wdataN.
- Write collision: we0 = we1 = 1 with waddr0 = waddr1 ≠ 0 → port 1 wins; port 0 data is discarded.
- Overflow flag, bit 0 of register[FLAG_IDX]. Per edge, apply in order:
  1. port writes;
  2. if ovf_clr, bit0 ← 0;
  3. if ovf_set, bit0 ← 1.
  - Consequences: set beats clear; set beats a same-cycle write of 0 to FLAG_IDX. Bits [DATA_W-1:1] follow writes only.
- Combinational read (READ_REG = 0): rdata_k = register[raddr_k].
  - With BYPASS = 1, a same-cycle write to raddr_k (≠ 0) is forwarded: port 1 has priority over port 0, then array contents.
  - Flag effects are not bypassed.
- Registered read (READ_REG = 1): at each edge, rdata_k ← post-edge value of register[raddr_k] (write-first, including flag effects). BYPASS is ignored.
- Out-of-range addresses cannot occur (depth = 2^ADDR_W).

## Timing
- Write latency: 1 edge. A value written at edge n is visible combinationally after edge n, or in the same cycle with BYPASS = 1.
- Registered reads: address presented in cycle n → data valid after edge n+1 and held until the next edge.
- ovf_flag changes on the edge after ovf_set/ovf_clr is sampled, or immediately on reset assertion.
- Reset asserted mid-operation: all registers and rdata are reinitialised immediately; pending writes, set and clear in that cycle are lost. The first write after reset deassertion takes effect on the first rising edge with rst = 1.
- No multicycle paths. All inputs are sampled only at the rising edge of clk.

## Test plan
- Reset: drive rst low asynchronously between edges. Require: read r28 = 32'h0000_1800, r29 = 32'h0000_2ffc, r5 = 0, ovf_flag = 0, and registered rdata = 0 without any clock edge.
- Write/read and r0: we0 with waddr0 = 7, wdata0 = 32'hDEAD_BEEF, then read r7 → DEAD_BEEF. A write of 32'h1234 to r0 → r0 reads 0.
- Collision and bypass (READ_REG = 0, BYPASS = 1): same cycle, port 0 writes r9 = 32'h1111 and port 1 writes r9 = 32'h2222, with raddr0 = 9. Require: rdata0 = 32'h2222 in that cycle and r9 = 32'h2222 afterwards.
- Flag priority: first r30 = 32'h0000_00F0. Then, in one cycle, write r30 = 0 on port 0 together with ovf_set and ovf_clr. Require: r30 = 32'h0000_0001 and ovf_flag = 1. Next cycle ovf_clr only → ovf_flag = 0.
- Registered reads (READ_REG = 1, NRD = 3, ADDR_W = 6, DATA_W = 16): write r40 = 16'hABCD with raddr2 = 40 in the same cycle. Require: rdata2 = 16'hABCD exactly one edge later, and the GP reset value truncated to 16'h1800.
- Reset mid-write: assert rst while we1 targets r3 with 32'h5555. Require: r3 = 0 after release. The first post-release write to r3 lands on the first edge.
